// File: rtl/softmax_pkg.sv
// ============================================================================
//  Module      : softmax_pkg
//  Description : Shared types and constants for the softmax stream controller:
//                controller state encoding, length-mode width and default
//                BRAM address / vector widths.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package softmax_pkg;

    localparam int ADDR_W_DEFAULT = 6;
    localparam int DATA_W_DEFAULT = 1024;
    localparam int LEN_MODE_W     = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/softmax_stream_ctrl_if.sv
// ============================================================================
//  Module      : softmax_stream_ctrl_if
//  Description : Host, BRAM-read and datapath signals of the softmax stream
//                controller. The master modport is the controller's view, the
//                slave modport is the surrounding system's view.
//                Optional performance outputs exist only when
//                SOFTMAX_CTRL_PERF_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface softmax_stream_ctrl_if #(
    parameter int ADDR_W = softmax_pkg::ADDR_W_DEFAULT,
    parameter int DATA_W = softmax_pkg::DATA_W_DEFAULT
);
    import softmax_pkg::*;

    // Host command / status
    logic                  start;
    logic [ADDR_W-1:0]     cfg_base;
    logic [ADDR_W:0]       cfg_count;
    logic [LEN_MODE_W-1:0] cfg_length_mode;
    logic                  busy;
    logic                  done;
    // BRAM read port
    logic                  bram_en;
    logic [ADDR_W-1:0]     bram_addr;
    logic [DATA_W-1:0]     bram_dout;
    // Datapath stream
    logic                  dp_valid;
    logic                  dp_ready;
    logic [DATA_W-1:0]     dp_data;
    logic [LEN_MODE_W-1:0] dp_length_mode;
    logic                  res_valid;
`ifdef SOFTMAX_CTRL_PERF_EN
    logic [31:0]           perf_cycles;
    logic [31:0]           perf_stalls;
`endif

    modport master (
        input  start, cfg_base, cfg_count, cfg_length_mode,
        input  bram_dout, dp_ready, res_valid,
`ifdef SOFTMAX_CTRL_PERF_EN
        output perf_cycles, perf_stalls,
`endif
        output busy, done, bram_en, bram_addr,
        output dp_valid, dp_data, dp_length_mode
    );

    modport slave (
        output start, cfg_base, cfg_count, cfg_length_mode,
        output bram_dout, dp_ready, res_valid,
`ifdef SOFTMAX_CTRL_PERF_EN
        input  perf_cycles, perf_stalls,
`endif
        input  busy, done, bram_en, bram_addr,
        input  dp_valid, dp_data, dp_length_mode
    );

endinterface

`default_nettype wire

// File: rtl/softmax_stream_ctrl_skid_fifo2.sv
// ============================================================================
//  Module      : skid_fifo2
//  Description : Two-entry FIFO with registered storage. Head is read
//                directly from storage; push and pop in one cycle are both
//                honoured. No ready output: the producer must account for
//                occupancy itself.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module skid_fifo2 #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_din,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_head,
    output logic      [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    // Storage, pointers and occupancy; storage is cleared so the head reads 0 out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 2'd1;
            end else if (!i_push && i_pop) begin
                r_count <= r_count - 2'd1;
            end
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(i_push && !i_pop && (r_count == 2'd2)));
    a_no_underflow : assert property (@(posedge clk) disable iff (rst)
        !(i_pop && (r_count == 2'd0)));

endmodule

`default_nettype wire

// File: rtl/softmax_stream_ctrl.sv
// ============================================================================
//  Module      : softmax_stream_ctrl
//  Description : Job sequencer between the input-vector BRAM and the softmax
//                datapath. Streams cfg_count vectors from cfg_base through a
//                two-entry skid FIFO, counts returned results and pulses done.
//                Optional: SOFTMAX_CTRL_PERF_EN adds busy-cycle and stall
//                counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module softmax_stream_ctrl
    import softmax_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  wire logic              clk,
    input  wire logic              rst,
    softmax_stream_ctrl_if.master  bus
);

    localparam int CW = ADDR_W + 1;
    localparam int FW = DATA_W + LEN_MODE_W;

    localparam logic [1:0] c_IDLE  = IDLE;
    localparam logic [1:0] c_RUN   = RUN;
    localparam logic [1:0] c_DRAIN = DRAIN;

    logic [1:0]            r_state;
    logic [ADDR_W-1:0]     r_base;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         r_issued;
    logic [CW-1:0]         r_sent;
    logic [CW-1:0]         r_recv;
    logic [LEN_MODE_W-1:0] r_mode;
    logic                  r_rd_pending;
    logic                  r_done;

    logic [1:0]            w_fifo_cnt;
    logic [FW-1:0]         w_fifo_head;
    logic                  w_fifo_empty;
    logic                  w_bypass;
    logic                  w_pop;
    logic                  w_fifo_push;
    logic                  w_fifo_pop;
    logic [2:0]            w_occ;
    logic                  w_issue;
    logic                  w_start_acc;
    logic [CW-1:0]         w_sent_next;
    logic [CW-1:0]         w_recv_next;

    // The read returning this cycle is presented straight from bram_dout when
    // the FIFO is empty, so a vector reaches the datapath one cycle after its
    // read. If it is not taken it is written into the FIFO at the edge and
    // stays on the outputs unchanged.
    assign w_fifo_empty = (w_fifo_cnt == 2'd0);
    assign w_bypass     = w_fifo_empty && r_rd_pending;

    assign bus.dp_valid       = !w_fifo_empty || r_rd_pending;
    assign bus.dp_data        = w_bypass ? bus.bram_dout : w_fifo_head[DATA_W-1:0];
    assign bus.dp_length_mode = w_bypass ? r_mode : w_fifo_head[FW-1:DATA_W];

    assign w_pop       = bus.dp_valid && bus.dp_ready;
    assign w_fifo_push = r_rd_pending && !(w_fifo_empty && w_pop);
    assign w_fifo_pop  = w_pop && !w_fifo_empty;

    // Vectors held or in flight after this cycle; a new read is allowed only
    // while that leaves room for its data in the two-entry FIFO.
    assign w_occ   = {1'b0, w_fifo_cnt} + {2'b00, r_rd_pending} - {2'b00, w_pop};
    assign w_issue = (r_state == c_RUN) && (r_issued < r_count) && (w_occ < 3'd2);

    assign bus.bram_en   = w_issue;
    assign bus.bram_addr = w_issue ? (r_base + r_issued[ADDR_W-1:0]) : '0;
    assign bus.busy      = (r_state == c_RUN) || (r_state == c_DRAIN);
    assign bus.done      = r_done;

    assign w_start_acc = (r_state == c_IDLE) && bus.start;
    assign w_sent_next = r_sent + {{ADDR_W{1'b0}}, w_pop};
    assign w_recv_next = r_recv + {{ADDR_W{1'b0}}, bus.res_valid};

    skid_fifo2 #(
        .WIDTH (FW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_fifo_push),
        .i_din   ({r_mode, bus.bram_dout}),
        .i_pop   (w_fifo_pop),
        .o_head  (w_fifo_head),
        .o_count (w_fifo_cnt)
    );

    // Job state machine: config latch, issue/send/result counters and done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_base       <= '0;
            r_count      <= '0;
            r_issued     <= '0;
            r_sent       <= '0;
            r_recv       <= '0;
            r_mode       <= '0;
            r_rd_pending <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done       <= 1'b0;
            r_rd_pending <= w_issue;
            if (w_issue) begin
                r_issued <= r_issued + CW'(1);
            end
            if (r_state != c_IDLE) begin
                r_sent <= w_sent_next;
                r_recv <= w_recv_next;
            end
            case (r_state)
                c_IDLE: begin
                    if (w_start_acc) begin
                        r_base   <= bus.cfg_base;
                        r_count  <= bus.cfg_count;
                        r_mode   <= bus.cfg_length_mode;
                        r_issued <= '0;
                        r_sent   <= '0;
                        r_recv   <= '0;
                        if (bus.cfg_count == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= c_RUN;
                        end
                    end
                end
                c_RUN: begin
                    if (w_sent_next == r_count) begin
                        r_state <= c_DRAIN;
                    end
                end
                c_DRAIN: begin
                    if (w_recv_next >= r_count) begin
                        r_state <= c_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

`ifdef SOFTMAX_CTRL_PERF_EN
    logic [31:0] r_perf_cycles;
    logic [31:0] r_perf_stalls;

    // Saturating busy-cycle and stall counters, cleared when a job is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_cycles <= '0;
            r_perf_stalls <= '0;
        end else if (w_start_acc) begin
            r_perf_cycles <= '0;
            r_perf_stalls <= '0;
        end else begin
            if (bus.busy && (r_perf_cycles != '1)) begin
                r_perf_cycles <= r_perf_cycles + 32'd1;
            end
            if (bus.dp_valid && !bus.dp_ready && (r_perf_stalls != '1)) begin
                r_perf_stalls <= r_perf_stalls + 32'd1;
            end
        end
    end

    assign bus.perf_cycles = r_perf_cycles;
    assign bus.perf_stalls = r_perf_stalls;
`endif

endmodule

`default_nettype wire
